// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider: clk_out = clk_in / D, with the divisor changed only at period boundaries.
// Optional CLKDIV_ODD50_EN adds a negedge re-timing flop for 50 % duty on odd divisors.
module clk_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_busy,
    output logic             div_err,
    output logic [CNT_W-1:0] div_active
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] pend_r;
    logic             clk_pos_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] half_s;
    logic             wrap_s;
    logic             load_ok_s;
    logic             load_bad_s;

    // Period boundary and load qualification, all derived from the divisor in effect
    always_comb begin
        last_s     = div_active - ONE;
        half_s     = div_active >> 1;
        wrap_s     = (cnt_r == last_s);
        cnt_nxt_s  = cnt_r + ONE;
        load_ok_s  = div_load && (div_val >= TWO);
        load_bad_s = div_load && (div_val < TWO);
    end

    // Counter and high/low phase generation; reset parks the counter one step before a wrap
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r     <= DIV_RST - ONE;
            clk_pos_r <= 1'b0;
            tick      <= 1'b0;
        end else if (en) begin
            if (wrap_s) begin
                cnt_r     <= {CNT_W{1'b0}};
                clk_pos_r <= 1'b1;
                tick      <= 1'b1;
            end else begin
                cnt_r <= cnt_nxt_s;
                tick  <= 1'b0;
                if (cnt_nxt_s == half_s) begin
                    clk_pos_r <= 1'b0;
                end else begin
                    clk_pos_r <= clk_pos_r;
                end
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Divisor staging: a new load always wins over clearing busy, so a load on a wrap edge waits a full period
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_active <= DIV_RST;
            pend_r     <= DIV_RST;
            div_busy   <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            div_err <= load_bad_s;
            if (en && wrap_s && div_busy) begin
                div_active <= pend_r;
            end else begin
                div_active <= div_active;
            end
            if (load_ok_s) begin
                pend_r   <= div_val;
                div_busy <= 1'b1;
            end else if (en && wrap_s) begin
                pend_r   <= pend_r;
                div_busy <= 1'b0;
            end else begin
                pend_r   <= pend_r;
                div_busy <= div_busy;
            end
        end
    end

`ifdef CLKDIV_ODD50_EN
    logic clk_neg_r;

    // Half-cycle delayed copy of the high phase, only for odd divisors
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            clk_neg_r <= 1'b0;
        end else begin
            clk_neg_r <= clk_pos_r & div_active[0];
        end
    end

    assign clk_out = clk_pos_r | clk_neg_r;
`else
    assign clk_out = clk_pos_r;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Randomized and directed bench for clk_divider_prog, checked against a period-position reference model.
module tb_clk_divider_prog;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 10;

    logic             clk_in;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_busy;
    logic             div_err;
    logic [CNT_W-1:0] div_active;

    int vectors;
    int miscompares;

    // Reference model: position inside the current period and the divisors in play
    int m_pos;
    int m_d;
    int m_pend;
    bit m_busy;
    bit exp_tick;
    bit exp_err;

    clk_divider_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .div_busy  (div_busy),
        .div_err   (div_err),
        .div_active(div_active)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_pos    = DIV_DEFAULT - 1;
        m_d      = DIV_DEFAULT;
        m_pend   = 0;
        m_busy   = 1'b0;
        exp_tick = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int v);
        exp_tick = 1'b0;
        if (e) begin
            if (m_pos == m_d - 1) begin
                m_pos    = 0;
                exp_tick = 1'b1;
                if (m_busy) begin
                    m_d    = m_pend;
                    m_busy = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        exp_err = ld && (v < 2);
        if (ld && v >= 2) begin
            m_pend = v;
            m_busy = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_clk;
        exp_clk = (m_pos < (m_d / 2));
        check({tag, ".clk_out"}, {31'd0, clk_out}, {31'd0, exp_clk});
        check({tag, ".tick"}, {31'd0, tick}, {31'd0, exp_tick});
        check({tag, ".div_busy"}, {31'd0, div_busy}, {31'd0, m_busy});
        check({tag, ".div_err"}, {31'd0, div_err}, {31'd0, exp_err});
        check({tag, ".div_active"}, {24'd0, div_active}, m_d);
    endtask

    // One clk_in period: drive inputs, advance model on the edge, compare 1 time unit later
    task automatic cycle(input string tag, input bit e, input bit ld, input int v);
        en       = e;
        div_load = ld;
        div_val  = v[CNT_W-1:0];
        @(posedge clk_in);
        model_edge(e, ld, v);
        #1;
        check_all(tag);
    endtask

    task automatic run_to(input string tag, input int target);
        int guard;
        guard = 0;
        while (m_pos != target && guard < 64) begin
            cycle(tag, 1'b1, 1'b0, 0);
            guard++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        en          = 1'b0;
        div_load    = 1'b0;
        div_val     = '0;
        model_reset();
        @(posedge clk_in);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Default divisor: 5 high / 5 low, tick every 10
        for (int i = 0; i < 25; i++) cycle("default", 1'b1, 1'b0, 0);

        // Reload to 4 in mid-period; old period must finish first
        run_to("align", 2);
        cycle("reload4", 1'b1, 1'b1, 4);
        for (int i = 0; i < 20; i++) cycle("div4", 1'b1, 1'b0, 0);

        // Odd divisor 3: 1 high / 2 low
        cycle("load3", 1'b1, 1'b1, 3);
        for (int i = 0; i < 15; i++) cycle("div3", 1'b1, 1'b0, 0);

        // Illegal loads are flagged and ignored
        cycle("bad1", 1'b1, 1'b1, 1);
        cycle("bad1_after", 1'b1, 1'b0, 0);
        cycle("bad0", 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) cycle("bad_after", 1'b1, 1'b0, 0);

        // Freeze during high phase of D=8
        cycle("load8", 1'b1, 1'b1, 8);
        run_to("align8", 1);
        run_to("align8", 0);
        for (int i = 0; i < 7; i++) cycle("freeze", 1'b0, 1'b0, 0);
        for (int i = 0; i < 18; i++) cycle("resume", 1'b1, 1'b0, 0);

        // Asynchronous reset with a pending divisor
        cycle("pend5", 1'b1, 1'b1, 5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk_in);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cycle("post_rst", 1'b1, 1'b0, 0);

        // Load 6 coincident with a wrap edge: applied one full period later
        run_to("align_wrap", m_d - 1);
        cycle("load6_wrap", 1'b1, 1'b1, 6);
        for (int i = 0; i < 24; i++) cycle("div6", 1'b1, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit ld;
            int v;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            v  = $urandom_range(0, 20);
            cycle("random", e, ld, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
